// File: rtl/pool2d_pkg.sv
// Shared helpers for the 2-D pooling window buffer: derived output dimensions,
// parameter sanity checks, raster-position record and stride-phase stepping.
package pool2d_pkg;

    localparam int CNT_W = 16;

    typedef struct packed {
        logic [CNT_W-1:0] row;
        logic [CNT_W-1:0] col;
        logic [CNT_W-1:0] row_phase;
        logic [CNT_W-1:0] col_phase;
    } win_pos_t;

    function automatic int pool_out_dim(input int in_dim, input int k, input int s);
        return (in_dim - k) / s + 1;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit pool_params_ok(input int in_w, input int in_h, input int kw,
                                          input int kh, input int s, input int pad);
        return (kw >= 1) && (kh >= 1) && (kw <= in_w) && (kh <= in_h) && (s >= 1) && (pad == 0);
    endfunction

    // Phase of the next index along one axis: zero while the window cannot yet fit,
    // then counting modulo the stride so a window fires whenever it returns to zero.
    function automatic logic [CNT_W-1:0] step_phase(input logic [CNT_W-1:0] cnt,
                                                    input logic [CNT_W-1:0] phase,
                                                    input int k, input int s);
        if (cnt < CNT_W'(k - 1))
            return '0;
        else if (phase == CNT_W'(s - 1))
            return '0;
        else
            return phase + 1'b1;
    endfunction

endpackage

// File: rtl/pool2d_raster_counter.sv
// Raster position tracker: row/col counters, stride phases and the circular
// row-buffer slot pointer; flags each accepted element that completes a window.
module pool2d_raster_counter
    import pool2d_pkg::*;
#(
    parameter int W  = 8,
    parameter int H  = 8,
    parameter int KW = 2,
    parameter int KH = 2,
    parameter int S  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    advance_i,
    output logic                    fire_o,
    output logic [idx_w(KH)-1:0]    slot_o,
    output logic [idx_w(W)-1:0]     col_cnt_o,
    output logic                    frame_last_o
);

    localparam int SLOT_W = idx_w(KH);
    localparam int COL_W  = idx_w(W);

    win_pos_t          pos_q, pos_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              col_last, row_last;

    assign col_last     = (pos_q.col == CNT_W'(W - 1));
    assign row_last     = (pos_q.row == CNT_W'(H - 1));
    assign frame_last_o = col_last && row_last;

    assign fire_o = advance_i
                 && (pos_q.row >= CNT_W'(KH - 1)) && (pos_q.row_phase == '0)
                 && (pos_q.col >= CNT_W'(KW - 1)) && (pos_q.col_phase == '0);

    assign slot_o    = slot_q;
    assign col_cnt_o = COL_W'(pos_q.col);

    // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        pos_d  = pos_q;
        slot_d = slot_q;
        if (advance_i) begin
            if (col_last) begin
                pos_d.col       = '0;
                pos_d.col_phase = '0;
                if (row_last) begin
                    pos_d.row       = '0;
                    pos_d.row_phase = '0;
                    slot_d          = '0;
                end else begin
                    pos_d.row       = pos_q.row + 1'b1;
                    pos_d.row_phase = step_phase(pos_q.row, pos_q.row_phase, KH, S);
                    slot_d          = (slot_q == SLOT_W'(KH - 1)) ? '0 : slot_q + 1'b1;
                end
            end else begin
                pos_d.col       = pos_q.col + 1'b1;
                pos_d.col_phase = step_phase(pos_q.col, pos_q.col_phase, KW, S);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q  <= '0;
            slot_q <= '0;
        end else begin
            pos_q  <= pos_d;
            slot_q <= slot_d;
        end
    end

endmodule

// File: rtl/pool2d_window_buffer.sv
// Streaming KHxKW window generator feeding the pool2d cores: circular row buffer,
// window mux with same-cycle bypass, and a single no-bubble output register.
module pool2d_window_buffer
    import pool2d_pkg::*;
#(
    parameter int DATA_IN_0_PRECISION_0 = 8,
    parameter int DATA_IN_0_PRECISION_1 = 3,
    parameter int DATA_IN_0_WIDTH       = 8,
    parameter int DATA_IN_0_HEIGHT      = 8,
    parameter int KERNEL_WIDTH          = 2,
    parameter int KERNEL_HEIGHT         = 2,
    parameter int STRIDE                = 2,
    parameter int PADDING               = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_IN_0_PRECISION_0-1:0] data_in_0,
    input  logic                             data_in_0_valid,
    output logic                             data_in_0_ready,
    output logic [DATA_IN_0_PRECISION_0-1:0] data_out_0 [KERNEL_HEIGHT*KERNEL_WIDTH],
    output logic                             data_out_0_valid,
    input  logic                             data_out_0_ready
);

    localparam int P0     = DATA_IN_0_PRECISION_0;
    localparam int W      = DATA_IN_0_WIDTH;
    localparam int KW     = KERNEL_WIDTH;
    localparam int KH     = KERNEL_HEIGHT;
    localparam int SLOT_W = idx_w(KH);
    localparam int COL_W  = idx_w(W);
    localparam int DATA_OUT_0_WIDTH  = pool_out_dim(DATA_IN_0_WIDTH, KERNEL_WIDTH, STRIDE);
    localparam int DATA_OUT_0_HEIGHT = pool_out_dim(DATA_IN_0_HEIGHT, KERNEL_HEIGHT, STRIDE);

    if (!pool_params_ok(DATA_IN_0_WIDTH, DATA_IN_0_HEIGHT, KERNEL_WIDTH, KERNEL_HEIGHT, STRIDE, PADDING)
        || DATA_OUT_0_WIDTH < 1 || DATA_OUT_0_HEIGHT < 1
        || DATA_IN_0_PRECISION_1 > DATA_IN_0_PRECISION_0) begin : g_bad_params
        $error("pool2d_window_buffer: need K<=IN, STRIDE>=1, PADDING==0");
    end

    logic              accept;
    logic              fire;
    logic              frame_last;
    logic [SLOT_W-1:0] slot;
    logic [COL_W-1:0]  col_cnt;

    logic [P0-1:0] line_q [KH][W];
    logic [P0-1:0] win_d  [KH*KW];
    logic [P0-1:0] data_q [KH*KW];
    logic          valid_q;

    assign data_in_0_ready = !valid_q || data_out_0_ready;
    assign accept          = data_in_0_valid && data_in_0_ready;

    pool2d_raster_counter #(
        .W  (DATA_IN_0_WIDTH),
        .H  (DATA_IN_0_HEIGHT),
        .KW (KERNEL_WIDTH),
        .KH (KERNEL_HEIGHT),
        .S  (STRIDE)
    ) u_raster (
        .clk          (clk),
        .rst_n        (rst),
        .advance_i    (accept),
        .fire_o       (fire),
        .slot_o       (slot),
        .col_cnt_o    (col_cnt),
        .frame_last_o (frame_last)
    );

    // NOTE: the line storage has no reset; every cell is written before a window can read it.
    always_ff @(posedge clk) begin
        if (accept)
            line_q[slot][col_cnt] <= data_in_0;
    end

    // Row m of the window lives in slot (slot+1+m) mod KH; the newest element is bypassed.
    always_comb begin : p_window_mux
        int rs;
        int cc;
        rs    = 0;
        cc    = 0;
        win_d = '{default: '0};
        for (int m = 0; m < KH; m++) begin
            rs = int'(slot) + 1 + m;
            if (rs >= KH)
                rs = rs - KH;
            for (int n = 0; n < KW; n++) begin
                cc = int'(col_cnt) - (KW - 1) + n;
                if (m == KH - 1 && n == KW - 1)
                    win_d[m*KW+n] = data_in_0;
                else
                    win_d[m*KW+n] = line_q[SLOT_W'(rs)][COL_W'(cc)];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '{default: '0};
        end else if (fire) begin
            valid_q <= 1'b1;
            data_q  <= win_d;
        end else if (data_out_0_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign data_out_0       = data_q;
    assign data_out_0_valid = valid_q;

endmodule

// File: tb/tb_pool2d_window_buffer.sv
// Directed and randomised checks of pool2d_window_buffer across four geometries:
// 4x4/S2, 3x3/S1, 5x5/S2 and 8x8/S2, all with a 2x2 kernel.
module tb_pool2d_window_buffer;

    logic       clk;
    logic       rst;
    logic [7:0] din [4];
    logic [3:0] vin;
    logic [3:0] ro;
    wire  [3:0] rdy;
    wire  [3:0] vo;
    logic [31:0] win [4];

    int checks = 0;
    int errors = 0;

    logic [33:0] cap [$];
    logic [31:0] exp_q [$];
    logic [7:0]  img [192];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar i = 0; i < 4; i++) begin : g_dut
        localparam int GW = (i == 0) ? 4 : (i == 1) ? 3 : (i == 2) ? 5 : 8;
        localparam int GS = (i == 1) ? 1 : 2;
        logic [7:0] dout [4];

        pool2d_window_buffer #(
            .DATA_IN_0_PRECISION_0 (8),
            .DATA_IN_0_PRECISION_1 (3),
            .DATA_IN_0_WIDTH       (GW),
            .DATA_IN_0_HEIGHT      (GW),
            .KERNEL_WIDTH          (2),
            .KERNEL_HEIGHT         (2),
            .STRIDE                (GS),
            .PADDING               (0)
        ) u_dut (
            .clk              (clk),
            .rst              (rst),
            .data_in_0        (din[i]),
            .data_in_0_valid  (vin[i]),
            .data_in_0_ready  (rdy[i]),
            .data_out_0       (dout),
            .data_out_0_valid (vo[i]),
            .data_out_0_ready (ro[i])
        );

        assign win[i] = {dout[3], dout[2], dout[1], dout[0]};
    end

    // Record every output handshake just before the edge on which it completes.
    always begin
        @(negedge clk);
        #4;
        for (int i = 0; i < 4; i++)
            if (vo[i] && ro[i])
                cap.push_back({2'(i), win[i]});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic send(input int d, input int v);
        int t;
        t = 0;
        @(negedge clk);
        din[d] = 8'(v);
        vin[d] = 1'b1;
        while (!rdy[d] && t < 200) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("send_ready_dut%0d", d), 64'(rdy[d]), 64'd1);
        @(posedge clk);
        #1;
        vin[d] = 1'b0;
    endtask

    task automatic compare_cap(input string tag, input int base, input int d);
        int n;
        n = cap.size() - base;
        check({tag, "_count"}, 64'(n), 64'(exp_q.size()));
        for (int j = 0; j < n && j < exp_q.size(); j++)
            check($sformatf("%s_win%0d", tag, j), 64'(cap[base+j]), 64'({2'(d), exp_q[j]}));
    endtask

    task automatic push_4x4;
        exp_q.delete();
        exp_q.push_back(pk(0, 1, 4, 5));
        exp_q.push_back(pk(2, 3, 6, 7));
        exp_q.push_back(pk(8, 9, 12, 13));
        exp_q.push_back(pk(10, 11, 14, 15));
    endtask

    initial begin
        int base;
        int sent;
        int cyc;
        logic [31:0] wexp;

        rst = 1'b0;
        vin = '0;
        ro  = '1;
        for (int i = 0; i < 4; i++) din[i] = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset_valid_dut%0d", i), 64'(vo[i]), 64'd0);
            check($sformatf("reset_data_dut%0d", i), 64'(win[i]), 64'd0);
        end
        rst = 1'b1;

        // 4x4, S=2: windows one cycle after elements 5, 7, 13, 15
        base = cap.size();
        for (int k = 0; k < 16; k++) begin
            send(0, k);
            check($sformatf("latency_valid_e%0d", k), 64'(vo[0]),
                  64'(k == 5 || k == 7 || k == 13 || k == 15));
            wexp = (k == 5)  ? pk(0, 1, 4, 5)     : (k == 7)  ? pk(2, 3, 6, 7) :
                   (k == 13) ? pk(8, 9, 12, 13)   : pk(10, 11, 14, 15);
            if (k == 5 || k == 7 || k == 13 || k == 15)
                check($sformatf("latency_data_e%0d", k), 64'(win[0]), 64'(wexp));
        end
        repeat (3) @(negedge clk);
        push_4x4();
        compare_cap("s2_4x4", base, 0);

        // 3x3, S=1
        base = cap.size();
        for (int k = 1; k <= 9; k++) send(1, k);
        repeat (3) @(negedge clk);
        exp_q.delete();
        exp_q.push_back(pk(1, 2, 4, 5));
        exp_q.push_back(pk(2, 3, 5, 6));
        exp_q.push_back(pk(4, 5, 7, 8));
        exp_q.push_back(pk(5, 6, 8, 9));
        compare_cap("s1_3x3", base, 1);

        // 5x5, S=2, two frames: remainder row/col dropped, second frame restarts cleanly
        base = cap.size();
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 25; k++) send(2, k);
        repeat (3) @(negedge clk);
        exp_q.delete();
        for (int f = 0; f < 2; f++) begin
            exp_q.push_back(pk(0, 1, 5, 6));
            exp_q.push_back(pk(2, 3, 7, 8));
            exp_q.push_back(pk(10, 11, 15, 16));
            exp_q.push_back(pk(12, 13, 17, 18));
        end
        compare_cap("s2_5x5", base, 2);

        // Backpressure: hold the first window for 5 cycles while element 6 waits
        base = cap.size();
        @(negedge clk);
        ro[0] = 1'b0;
        for (int k = 0; k < 6; k++) send(0, k);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            din[0] = 8'd6;
            vin[0] = 1'b1;
            #1;
            check($sformatf("bp_in_ready_c%0d", c), 64'(rdy[0]), 64'd0);
            check($sformatf("bp_valid_c%0d", c), 64'(vo[0]), 64'd1);
            check($sformatf("bp_stable_c%0d", c), 64'(win[0]), 64'(pk(0, 1, 4, 5)));
        end
        ro[0]  = 1'b1;
        vin[0] = 1'b0;
        for (int k = 6; k < 16; k++) send(0, k);
        repeat (3) @(negedge clk);
        push_4x4();
        compare_cap("backpressure", base, 0);

        // Reset after 6 elements: the pending window must be discarded
        base = cap.size();
        for (int k = 0; k < 6; k++) send(0, k);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_valid", 64'(vo[0]), 64'd0);
        check("midrst_data", 64'(win[0]), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 16; k++) send(0, k);
        repeat (3) @(negedge clk);
        push_4x4();
        compare_cap("mid_reset", base, 0);

        // 8x8, S=2, three back-to-back frames with random valid/ready
        for (int k = 0; k < 192; k++) img[k] = 8'($urandom_range(0, 255));
        base = cap.size();
        sent = 0;
        cyc  = 0;
        while (sent < 192 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            vin[3] = ($urandom_range(0, 3) != 0);
            din[3] = img[sent];
            ro[3]  = ($urandom_range(0, 3) != 0);
            #4;
            if (vin[3] && rdy[3]) sent++;
        end
        @(negedge clk);
        vin[3] = 1'b0;
        ro[3]  = 1'b1;
        repeat (4) @(negedge clk);
        check("rand_elements_sent", 64'(sent), 64'd192);
        exp_q.delete();
        for (int f = 0; f < 3; f++)
            for (int r = 0; r < 8; r += 2)
                for (int c = 0; c < 8; c += 2)
                    exp_q.push_back(pk(img[f*64 + r*8 + c],     img[f*64 + r*8 + c + 1],
                                       img[f*64 + (r+1)*8 + c], img[f*64 + (r+1)*8 + c + 1]));
        compare_cap("rand_8x8", base, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
